// File: rtl/adc_if_pkg.sv
// Shared state codes, timing defaults and the per-state reset map for the
// ADC interface bring-up sequencer.
package adc_if_pkg;

    typedef enum logic [3:0] {
        RST_ALL       = 4'd0,
        IDC_HOLD      = 4'd1,
        WAIT_RDY      = 4'd2,
        REL_BUFR      = 4'd3,
        REL_IODLY_CLK = 4'd4,
        REL_IODLY_DAT = 4'd5,
        REL_ISERDES   = 4'd6,
        REL_SYNC      = 4'd7,
        DONE          = 4'd8,
        ERR           = 4'd9
    } state_t;

    localparam int T_IDC_RST_DEF = 16;
    localparam int T_STEP_DEF    = 8;
    localparam int T_RDY_TO_DEF  = 4096;
    localparam int MAX_RETRY_DEF = 3;
    localparam int CNT_W         = 13;

    // Bit order: {idelayctrl, bufr, iodelay_clk, iodelay_dat, iserdes, data_sync}.
    // Each release state keeps everything released by the states before it low.
    function automatic logic [5:0] rst_for_state(input state_t s);
        logic [5:0] r;
        r = 6'b111111;
        case (s)
            WAIT_RDY:      r = 6'b011111;
            REL_BUFR:      r = 6'b001111;
            REL_IODLY_CLK: r = 6'b000111;
            REL_IODLY_DAT: r = 6'b000011;
            REL_ISERDES:   r = 6'b000001;
            REL_SYNC:      r = 6'b000000;
            DONE:          r = 6'b000000;
            default:       r = 6'b111111;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic arst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_if_init_seq.sv
// ADC interface bring-up sequencer: holds IDELAYCTRL in reset, waits for ready,
// then releases BUFR/IODELAY/ISERDES/CDC resets in order with retry and error handling.
module adc_if_init_seq
    import adc_if_pkg::*;
#(
    parameter int T_IDC_RST = T_IDC_RST_DEF,
    parameter int T_STEP    = T_STEP_DEF,
    parameter int T_RDY_TO  = T_RDY_TO_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       restart,
    input  logic       idelayctrl_rdy,
    output logic       rst_idelayctrl,
    output logic       rst_bufr,
    output logic       rst_iodelay_clk,
    output logic       rst_iodelay_dat,
    output logic       rst_iserdes,
    output logic       rst_data_sync,
    output logic       if_ready,
    output logic       if_error,
    output logic [3:0] state_o,
    output logic [1:0] retry_cnt
);

    localparam logic [CNT_W-1:0] IDC_LAST  = CNT_W'(T_IDC_RST - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(T_STEP - 1);
    localparam logic [CNT_W-1:0] RDY_LAST  = CNT_W'(T_RDY_TO - 1);

    state_t           state, nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       retry_nxt;
    logic [5:0]       rst_vec;
    logic             rdy_s;
    logic             started;

    sync_2ff u_rdy_sync (
        .clk  (clk),
        .arst (arst),
        .d    (idelayctrl_rdy),
        .q    (rdy_s)
    );

    always_comb begin
        nxt       = state;
        retry_nxt = retry_cnt;
        if (restart) begin
            nxt       = RST_ALL;
            retry_nxt = 2'd0;
        end else begin
            case (state)
                // The first edge after arst release is spent in RST_ALL itself.
                RST_ALL:  if (started) nxt = IDC_HOLD;
                IDC_HOLD: if (cnt == IDC_LAST) nxt = WAIT_RDY;
                WAIT_RDY: begin
                    if (rdy_s) begin
                        nxt = REL_BUFR;
                    end else if (cnt == RDY_LAST) begin
                        retry_nxt = (retry_cnt == 2'b11) ? retry_cnt : retry_cnt + 2'd1;
                        nxt       = (int'(retry_cnt) + 1 < MAX_RETRY) ? IDC_HOLD : ERR;
                    end
                end
                REL_BUFR:      nxt = !rdy_s ? RST_ALL : (cnt == STEP_LAST) ? REL_IODLY_CLK : state;
                REL_IODLY_CLK: nxt = !rdy_s ? RST_ALL : (cnt == STEP_LAST) ? REL_IODLY_DAT : state;
                REL_IODLY_DAT: nxt = !rdy_s ? RST_ALL : (cnt == STEP_LAST) ? REL_ISERDES   : state;
                REL_ISERDES:   nxt = !rdy_s ? RST_ALL : (cnt == STEP_LAST) ? REL_SYNC      : state;
                REL_SYNC:      nxt = !rdy_s ? RST_ALL : (cnt == STEP_LAST) ? DONE          : state;
                DONE:          if (!rdy_s) nxt = RST_ALL;
                ERR:           nxt = ERR;
                default:       nxt = RST_ALL;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state_o.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= RST_ALL;
            started   <= 1'b0;
            retry_cnt <= 2'd0;
            rst_vec   <= 6'b111111;
            if_ready  <= 1'b0;
            if_error  <= 1'b0;
        end else begin
            state     <= nxt;
            started   <= 1'b1;
            retry_cnt <= retry_nxt;
            rst_vec   <= rst_for_state(nxt);
            if_ready  <= (nxt == DONE);
            if_error  <= (nxt == ERR);
        end
    end

    // Dwell counter restarts on every transition (including a restart into RST_ALL) and saturates.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt <= '0;
        end else if (restart || (nxt != state)) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign rst_idelayctrl  = rst_vec[5];
    assign rst_bufr        = rst_vec[4];
    assign rst_iodelay_clk = rst_vec[3];
    assign rst_iodelay_dat = rst_vec[2];
    assign rst_iserdes     = rst_vec[1];
    assign rst_data_sync   = rst_vec[0];
    assign state_o         = state;

endmodule

// File: tb/tb_adc_if_init_seq.sv
// Directed bench for adc_if_init_seq: nominal table plus recovery, timeout,
// restart, collision and async-reset sequences, all at default parameters.
module tb_adc_if_init_seq;

    logic       clk = 1'b0;
    logic       arst;
    logic       restart;
    logic       idelayctrl_rdy;
    logic       rst_idelayctrl, rst_bufr, rst_iodelay_clk, rst_iodelay_dat;
    logic       rst_iserdes, rst_data_sync, if_ready, if_error;
    logic [3:0] state_o;
    logic [1:0] retry_cnt;
    logic [5:0] rs;

    int n_vec = 0;
    int n_bad = 0;

    adc_if_init_seq dut (
        .clk             (clk),
        .arst            (arst),
        .restart         (restart),
        .idelayctrl_rdy  (idelayctrl_rdy),
        .rst_idelayctrl  (rst_idelayctrl),
        .rst_bufr        (rst_bufr),
        .rst_iodelay_clk (rst_iodelay_clk),
        .rst_iodelay_dat (rst_iodelay_dat),
        .rst_iserdes     (rst_iserdes),
        .rst_data_sync   (rst_data_sync),
        .if_ready        (if_ready),
        .if_error        (if_error),
        .state_o         (state_o),
        .retry_cnt       (retry_cnt)
    );

    always #5 clk = ~clk;

    assign rs = {rst_idelayctrl, rst_bufr, rst_iodelay_clk, rst_iodelay_dat, rst_iserdes, rst_data_sync};

    typedef struct {
        logic       rdy;
        int         n;
        logic [3:0] st;
        logic [5:0] rs;
        logic       rd;
        logic       er;
        logic [1:0] rt;
    } vec_t;

    vec_t tbl [0:13];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] st, input logic [5:0] r,
                             input logic rd, input logic er, input logic [1:0] rt);
        chk({tag, ".state"},  {4'd0, state_o},   {4'd0, st});
        chk({tag, ".resets"}, {2'd0, rs},        {2'd0, r});
        chk({tag, ".ready"},  {7'd0, if_ready},  {7'd0, rd});
        chk({tag, ".error"},  {7'd0, if_error},  {7'd0, er});
        chk({tag, ".retry"},  {6'd0, retry_cnt}, {6'd0, rt});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1,   4'd0, 6'h3F, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1,   4'd1, 6'h3F, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 15,  4'd1, 6'h3F, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 1,   4'd2, 6'h1F, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{1'b0, 100, 4'd2, 6'h1F, 1'b0, 1'b0, 2'd0};
        tbl[5]  = '{1'b1, 2,   4'd2, 6'h1F, 1'b0, 1'b0, 2'd0};
        tbl[6]  = '{1'b1, 1,   4'd3, 6'h0F, 1'b0, 1'b0, 2'd0};
        tbl[7]  = '{1'b1, 7,   4'd3, 6'h0F, 1'b0, 1'b0, 2'd0};
        tbl[8]  = '{1'b1, 1,   4'd4, 6'h07, 1'b0, 1'b0, 2'd0};
        tbl[9]  = '{1'b1, 8,   4'd5, 6'h03, 1'b0, 1'b0, 2'd0};
        tbl[10] = '{1'b1, 8,   4'd6, 6'h01, 1'b0, 1'b0, 2'd0};
        tbl[11] = '{1'b1, 8,   4'd7, 6'h00, 1'b0, 1'b0, 2'd0};
        tbl[12] = '{1'b1, 8,   4'd8, 6'h00, 1'b1, 1'b0, 2'd0};
        tbl[13] = '{1'b1, 20,  4'd8, 6'h00, 1'b1, 1'b0, 2'd0};

        arst = 1'b1;
        restart = 1'b0;
        idelayctrl_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_out("reset", 4'd0, 6'h3F, 1'b0, 1'b0, 2'd0);
        arst = 1'b0;

        // Nominal bring-up
        for (int i = 0; i < 14; i++) begin
            idelayctrl_rdy = tbl[i].rdy;
            step(tbl[i].n);
            check_out($sformatf("nom[%0d]", i), tbl[i].st, tbl[i].rs, tbl[i].rd, tbl[i].er, tbl[i].rt);
        end

        // Ready drops in DONE: RST_ALL three edges later, then full re-run
        idelayctrl_rdy = 1'b0;
        step(2);
        check_out("drop.hold", 4'd8, 6'h00, 1'b1, 1'b0, 2'd0);
        step(1);
        check_out("drop.rst", 4'd0, 6'h3F, 1'b0, 1'b0, 2'd0);
        idelayctrl_rdy = 1'b1;
        step(57);
        check_out("rerun.sync", 4'd7, 6'h00, 1'b0, 1'b0, 2'd0);
        step(1);
        check_out("rerun.done", 4'd8, 6'h00, 1'b1, 1'b0, 2'd0);

        // Three timeouts to ERR
        idelayctrl_rdy = 1'b0;
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check_out("to.start", 4'd0, 6'h3F, 1'b0, 1'b0, 2'd0);
        step(4112);
        check_out("to1.edge", 4'd2, 6'h1F, 1'b0, 1'b0, 2'd0);
        step(1);
        check_out("to1", 4'd1, 6'h3F, 1'b0, 1'b0, 2'd1);
        step(16);
        check_out("to2.wait", 4'd2, 6'h1F, 1'b0, 1'b0, 2'd1);
        step(4095);
        check_out("to2.edge", 4'd2, 6'h1F, 1'b0, 1'b0, 2'd1);
        step(1);
        check_out("to2", 4'd1, 6'h3F, 1'b0, 1'b0, 2'd2);
        step(16 + 4095);
        check_out("to3.edge", 4'd2, 6'h1F, 1'b0, 1'b0, 2'd2);
        step(1);
        check_out("to3.err", 4'd9, 6'h3F, 1'b0, 1'b1, 2'd3);
        idelayctrl_rdy = 1'b1;
        step(20);
        check_out("err.stay", 4'd9, 6'h3F, 1'b0, 1'b1, 2'd3);

        // Leave ERR by restart, take one timeout, then restart in REL_ISERDES
        idelayctrl_rdy = 1'b0;
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check_out("err.exit", 4'd0, 6'h3F, 1'b0, 1'b0, 2'd0);
        step(4113);
        check_out("rs.to1", 4'd1, 6'h3F, 1'b0, 1'b0, 2'd1);
        idelayctrl_rdy = 1'b1;
        step(41);
        check_out("rs.iserdes", 4'd6, 6'h01, 1'b0, 1'b0, 2'd1);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check_out("rs.restart", 4'd0, 6'h3F, 1'b0, 1'b0, 2'd0);

        // Restart coinciding with the WAIT_RDY timeout
        idelayctrl_rdy = 1'b0;
        step(4112);
        check_out("col.edge", 4'd2, 6'h1F, 1'b0, 1'b0, 2'd0);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check_out("col.rst", 4'd0, 6'h3F, 1'b0, 1'b0, 2'd0);
        step(1);
        check_out("col.hold", 4'd1, 6'h3F, 1'b0, 1'b0, 2'd0);

        // Asynchronous reset in REL_IODLY_DAT
        idelayctrl_rdy = 1'b1;
        step(33);
        check_out("ar.dat", 4'd5, 6'h03, 1'b0, 1'b0, 2'd0);
        #2 arst = 1'b1;
        #1 check_out("ar.async", 4'd0, 6'h3F, 1'b0, 1'b0, 2'd0);
        step(1);
        arst = 1'b0;
        step(1);
        check_out("ar.rstall", 4'd0, 6'h3F, 1'b0, 1'b0, 2'd0);
        step(1);
        check_out("ar.hold", 4'd1, 6'h3F, 1'b0, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_if_init_seq.md
ADC_IF_INIT_SEQ -- requirements
Module: adc_if_init_seq

Interface
REQ-001 SHALL have parameter T_IDC_RST, default 16: cycles rst_idelayctrl is held after entry to IDC_HOLD.
REQ-002 SHALL have parameter T_STEP, default 8: cycles between successive reset releases.
REQ-003 SHALL have parameter T_RDY_TO, default 4096: cycles allowed for idelayctrl_rdy to assert.
REQ-004 SHALL have parameter MAX_RETRY, default 3: timeouts tolerated before ERR.
REQ-005 SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  sequencer clock (FPGA main clock)
- arst  in  1  asynchronous reset, active-high
REQ-006 SHALL have the remaining ports:
- restart  in  1  single-cycle pulse; restarts the full sequence
- idelayctrl_rdy  in  1  asynchronous to clk; IDELAYCTRL ready
- rst_idelayctrl  out  1  IDELAYCTRL reset
- rst_bufr  out  1  BUFR reset
- rst_iodelay_clk  out  1  clock IODELAY reset
- rst_iodelay_dat  out  1  data IODELAY reset
- rst_iserdes  out  1  ISERDES reset
- rst_data_sync  out  1  CDC FIFO reset
- if_ready  out  1  interface up
- if_error  out  1  sequence failed
- state_o  out  4  current state code
- retry_cnt  out  2  timeouts seen in the current sequence

Function
REQ-007 SHALL synchronise idelayctrl_rdy through a 2-flop synchroniser (rdy_s) before any use.
REQ-008 SHALL implement states and codes: RST_ALL=0, IDC_HOLD=1, WAIT_RDY=2, REL_BUFR=3, REL_IODLY_CLK=4, REL_IODLY_DAT=5, REL_ISERDES=6, REL_SYNC=7, DONE=8, ERR=9.
REQ-009 RST_ALL SHALL last exactly 1 cycle with all six resets high, then go to IDC_HOLD.
REQ-010 IDC_HOLD SHALL count T_IDC_RST cycles with all resets high, then go to WAIT_RDY.
REQ-011 WAIT_RDY SHALL drive rst_idelayctrl low and count cycles.
- rdy_s=1: go to REL_BUFR.
- T_RDY_TO cycles elapse with rdy_s=0: increment retry_cnt; go to IDC_HOLD if retry_cnt+1 < MAX_RETRY, else to ERR.
REQ-012 Each REL_* state SHALL deassert its named reset on entry and dwell T_STEP cycles before advancing.
- Order: REL_BUFR -> REL_IODLY_CLK -> REL_IODLY_DAT -> REL_ISERDES -> REL_SYNC -> DONE.
- A reset released in one state SHALL stay low in all later states.
REQ-013 DONE SHALL drive all resets low and if_ready=1; if_ready SHALL be 1 only in DONE.
REQ-014 ERR SHALL drive if_error=1 with all resets high, and SHALL leave ERR only on restart or arst.
REQ-015 In any state from REL_BUFR through DONE, rdy_s=0 SHALL force RST_ALL on the next cycle; retry_cnt is unchanged.
REQ-016 restart=1 in any state SHALL force RST_ALL on the next cycle and clear retry_cnt; restart takes priority over every other transition in the same cycle.
REQ-017 The dwell counter SHALL be 13 bits, SHALL clear on every state change, and SHALL NOT wrap within any state.
REQ-018 All outputs SHALL be registered: outputs follow state_o with 0-cycle skew, and state_o changes 1 cycle after the transition condition.

Reset
REQ-019 On arst=1, all six reset outputs SHALL be 1, if_ready=0, if_error=0, state_o=0, retry_cnt=0, the counter SHALL be 0 and the synchroniser SHALL be 0.
REQ-020 After arst is released, the sequence SHALL start at RST_ALL on the first clk edge.

Structure
REQ-021 The state codes and parameter defaults SHALL live in shared package adc_if_pkg.
REQ-022 The 2-flop synchroniser SHALL be a separate sub-module, sync_2ff.

Verification
REQ-023 Nominal: rdy rises 100 cycles after WAIT_RDY entry (defaults) -> resets release in order at 8-cycle spacing; if_ready=1 in DONE; retry_cnt=0.
REQ-024 Timeout: rdy held 0 -> retry_cnt counts 1, then 2, then 3 at 4096-cycle timeouts; state goes to ERR with if_error=1 and all resets high.
REQ-025 Recovery: rdy drops while in DONE -> RST_ALL 3 cycles after the drop (2 synchroniser + 1 register); if_ready falls; the full sequence completes again once rdy returns.
REQ-026 Restart during REL_ISERDES -> next state RST_ALL with all resets high; retry_cnt=0.
REQ-027 Collision: restart and the WAIT_RDY timeout in the same cycle -> RST_ALL; retry_cnt=0, not incremented.
REQ-028 arst asserted mid-REL_IODLY_DAT -> outputs reach their reset values asynchronously, before the next clk edge; after release the sequence restarts at RST_ALL.
